// File: rtl/cnn_mac_arb_pkg.sv
// Shared widths and the beat record for the round-robin MAC arbiter.
package cnn_mac_arb_pkg;

  localparam int A_W       = 10;
  localparam int B_W       = 14;
  localparam int P_W       = A_W + B_W;
  localparam int ACC_W_DEF = 32;

  // Operand pair plus end-of-dot-product flag, as captured in S1.
  typedef struct packed {
    logic signed [A_W-1:0] a;
    logic signed [B_W-1:0] b;
    logic                  last;
  } beat_t;

endpackage

// File: rtl/cnn_mac_arb_mul.sv
// Signed 10x14 -> 24 multiply; purely combinational so it folds into a DSP slice
// between the S1 and S2 registers.
module cnn_mac_arb_mul
  import cnn_mac_arb_pkg::*;
(
  input  logic signed [A_W-1:0] a_i,
  input  logic signed [B_W-1:0] b_i,
  output logic signed [P_W-1:0] p_o
);

  assign p_o = a_i * b_i;

endmodule

// File: rtl/cnn_mac_arb.sv
// N_REQ requesters share one multiplier through a round-robin arbiter.
// Pipeline: S1 (operands) -> mul -> S2 (product) -> S3 (accumulate / output).
module cnn_mac_arb
  import cnn_mac_arb_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic                                   ap_clk,
  input  logic                                   ap_rst_n,
  input  logic [N_REQ-1:0]                       req_valid,
  output logic [N_REQ-1:0]                       req_ready,
  input  logic [N_REQ*A_W-1:0]                   req_a,
  input  logic [N_REQ*B_W-1:0]                   req_b,
  input  logic [N_REQ-1:0]                       req_last,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [(N_REQ>1?$clog2(N_REQ):1)-1:0]   out_id,
  output logic [ACC_W-1:0]                       out_data
);

  localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [ID_W-1:0]             ptr_q;
  logic [ID_W-1:0]             gnt_id, hi_id, lo_id;
  logic                        gnt_any, hi_any, lo_any;
  logic                        stall, accept;
  beat_t                       sel_beat;

  // vld_pipe_q[0] = S1 valid, vld_pipe_q[1] = S2 valid
  logic [1:0]                  vld_pipe_q;
  beat_t                       s1_q;
  logic [ID_W-1:0]             s1_id_q;
  logic signed [P_W-1:0]       prod;
  logic signed [P_W-1:0]       s2_prod_q;
  logic [ID_W-1:0]             s2_id_q;
  logic                        s2_last_q;

  logic [N_REQ-1:0][ACC_W-1:0] acc_q;
  logic [ACC_W-1:0]            sum;

  logic                        out_valid_q;
  logic [ID_W-1:0]             out_id_q;
  logic [ACC_W-1:0]            out_data_q;

  // Only a finished result that cannot leave the output register blocks the pipe.
  assign stall = out_valid_q & ~out_ready & vld_pipe_q[1] & s2_last_q;

  // Round-robin pick: lowest valid index above the pointer, else lowest at/below it.
  always_comb begin
    hi_any = 1'b0;
    lo_any = 1'b0;
    hi_id  = '0;
    lo_id  = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        if (i > int'(ptr_q)) begin
          hi_any = 1'b1;
          hi_id  = ID_W'(i);
        end else begin
          lo_any = 1'b1;
          lo_id  = ID_W'(i);
        end
      end
    end
    gnt_any = hi_any | lo_any;
    gnt_id  = hi_any ? hi_id : lo_id;
  end

  // One-hot ready; never raised in reset or while the pipe is stalled.
  always_comb begin
    req_ready = '0;
    if (ap_rst_n && gnt_any && !stall) req_ready[gnt_id] = 1'b1;
  end

  assign accept = ap_rst_n & gnt_any & ~stall;

  // Operand mux for the granted requester.
  always_comb begin
    sel_beat = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt_id == ID_W'(i)) begin
        sel_beat.a    = req_a[i*A_W +: A_W];
        sel_beat.b    = req_b[i*B_W +: B_W];
        sel_beat.last = req_last[i];
      end
    end
  end

  // Arbiter pointer moves only on an accepted beat.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n)   ptr_q <= ID_W'(N_REQ - 1);
    else if (accept) ptr_q <= gnt_id;
  end

  // S1 and S2 registers; both freeze as a unit on stall.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      vld_pipe_q <= '0;
      s1_q       <= '0;
      s1_id_q    <= '0;
      s2_prod_q  <= '0;
      s2_id_q    <= '0;
      s2_last_q  <= 1'b0;
    end else if (!stall) begin
      vld_pipe_q <= {vld_pipe_q[0], accept};
      if (accept) begin
        s1_q    <= sel_beat;
        s1_id_q <= gnt_id;
      end
      s2_prod_q <= prod;
      s2_id_q   <= s1_id_q;
      s2_last_q <= s1_q.last;
    end
  end

  cnn_mac_arb_mul u_mul (
    .a_i (s1_q.a),
    .b_i (s1_q.b),
    .p_o (prod)
  );

  // Sign-extended product added to the owner's running sum, wrapping at ACC_W.
  assign sum = acc_q[s2_id_q] + ACC_W'(s2_prod_q);

  // S3 accumulators: partial sums kept, finished sums cleared for the next dot product.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      acc_q <= '0;
    end else if (vld_pipe_q[1] && !stall) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (s2_id_q == ID_W'(i)) acc_q[i] <= s2_last_q ? '0 : sum;
      end
    end
  end

  // Output register: loads on a last beat (also straight after a handshake), else drains.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      out_valid_q <= 1'b0;
      out_id_q    <= '0;
      out_data_q  <= '0;
    end else if (vld_pipe_q[1] && s2_last_q && !stall) begin
      out_valid_q <= 1'b1;
      out_id_q    <= s2_id_q;
      out_data_q  <= sum;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid = out_valid_q;
  assign out_id    = out_id_q;
  assign out_data  = out_data_q;

endmodule
